div_period_meter: RTL and testbench
===================================

# div_period_meter

Downstream checker stage for the frequency divider. It consumes the divided output `out` (wired here as `div_in`) together with the 3-bit ratio `in` that programs the divider. It measures the period and high time of `div_in` in `clk` cycles and reports each completed period with a one-cycle valid strobe. It compares the period against the programmed ratio and flags timeouts.

## Interface
- `CNT_W`, default 8: width of the period, high-time and internal counters.
- `clk`  input  1: single clock; the same clock that drives the divider, so `div_in` is synchronous to it.
- `rst`  input  1: asynchronous, active-low reset.
- `div_in`  input  1: divided signal from the divider's `out`.
- `ratio`  input  3: divide ratio currently applied to the divider's `in`.
- `meas_en`  input  1: enables measurement; low returns the block to IDLE.
- `valid`  output  1: one-cycle pulse when a full period has been measured.
- `period`  output  CNT_W: clk cycles between the last two rising edges of `div_in`.
- `high_time`  output  CNT_W: clk cycles `div_in` was high within that period.
- `match`  output  1: `period == ratio` and `ratio >= 2`; valid only while `valid` is high.
- `err_timeout`  output  1: sticky; no rising edge was seen for 2^CNT_W−1 cycles.
- `err_duty`  output  1: sticky duty-cycle error (see Configuration).

## Operation
- `div_q` is a one-cycle registered copy of `div_in`.
  - rise = `div_in & ~div_q`
  - fall = `~div_in & div_q`
- FSM states:
  - IDLE: counters cleared. Goes to ARM when `meas_en` = 1.
  - ARM: waits for the first rise. On rise: `cnt` <= 1, go to MEAS. No `valid` is produced for this first edge.
  - MEAS: `cnt` increments every cycle.
    - On fall: `hi_cap` <= `cnt`.
    - On rise: `period` <= `cnt`, `high_time` <= `hi_cap`, `match` updated, `valid` <= 1, `cnt` <= 1. Stays in MEAS.
- `meas_en` = 0 in any state: go to IDLE next cycle and clear `err_timeout` and `err_duty`. `period`, `high_time` and `match` hold their last values.
- Ratio change: the registered `ratio` is compared every cycle. A change while in MEAS goes to ARM and discards the partial period, so no `valid` is produced for it.
- Timeout: if `cnt` reaches 2^CNT_W−1 in MEAS without a rise, `err_timeout` <= 1 (sticky) and the FSM goes to ARM. `cnt` never wraps.
- `ratio` 0 or 1: measurement runs normally; `match` is forced to 0.
- Rise and ratio change in the same cycle: the ratio change wins; no `valid`.
- Rise and timeout in the same cycle: the rise wins; the period is reported and no error is raised.
- Arithmetic: `cnt` is CNT_W bits unsigned. For comparison, `ratio` is zero-extended to CNT_W.

## Timing
- Reset (`rst` low, asynchronous): state = IDLE; `cnt`, `hi_cap`, `div_q` = 0.
  - Outputs: `valid`, `period`, `high_time`, `match`, `err_timeout`, `err_duty` = 0.
- Deassertion of `rst` is assumed synchronised upstream. The first active edge after deassertion may leave IDLE.
- Latency: `div_in` rising is sampled at clk edge k. `valid`, `period`, `high_time` and `match` are registered at edge k and visible during cycle k.
- `valid` is high for exactly one cycle per measured period.
- Minimum measurable period is 2 cycles, because rise and fall need separate samples.
- Reset mid-measurement aborts immediately. No `valid` appears until one ARM edge plus one full period has elapsed.

## Configuration
- `DIV_MON_DUTY_CHK_EN` defined:
  - On each rise in MEAS, `err_duty` <= 1 (sticky) if |2·`high_time` − `period`| > 1, i.e. high and low time differ by more than one cycle.
  - The check applies only when `ratio >= 2`.
  - `err_duty` is cleared by reset or by `meas_en` = 0.
- Macro undefined: `err_duty` is tied to 0 and the comparison logic is not built. `high_time` is still measured and reported.

## Test plan
- Divide-by-4, `div_in` pattern 1100 repeating, `ratio` = 4, `meas_en` = 1: the first rise arms with no `valid`. Every subsequent rise gives `valid` = 1, `period` = 4, `high_time` = 2, `match` = 1, `err_duty` = 0.
- Divide-by-5, `div_in` 11000 repeating, `ratio` = 5: `period` = 5, `high_time` = 2, `match` = 1. `err_duty` = 0 (|4−5| = 1).
- Divide-by-6, `div_in` 100000 repeating, `ratio` = 6, macro defined: `period` = 6, `high_time` = 1, `err_duty` = 1. With the macro undefined, `err_duty` = 0.
- `ratio` changes 4→3 mid-period: no `valid` for the interrupted period. After a new arm edge, `period` = 3 and `match` = 1.
- `div_in` held low for 300 cycles, CNT_W = 8, in MEAS: `err_timeout` = 1 at cnt = 255 and stays 1. Driving `meas_en` = 0 clears it.
- Assert `rst` low mid-period with `period` = 4 latched: all outputs read 0 immediately without a clock edge. After release, the first `valid` follows one arm edge plus one full period.

Source files
------------

// File: rtl/div_period_meter_if.sv
// rtl/div_period_meter_if.sv - divider output, ratio and measurement result signals
interface div_period_meter_if #(
    parameter int CNT_W = 8
);
    logic             div_in;
    logic [2:0]       ratio;
    logic             meas_en;
    logic             valid;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             match;
    logic             err_timeout;
    logic             err_duty;

    modport master (
        output div_in, ratio, meas_en,
        input  valid, period, high_time, match, err_timeout, err_duty
    );

    modport slave (
        input  div_in, ratio, meas_en,
        output valid, period, high_time, match, err_timeout, err_duty
    );
endinterface

// File: rtl/div_period_meter.sv
// rtl/div_period_meter.sv - period/high-time meter for the divider output
// Optional duty-cycle check built when DIV_MON_DUTY_CHK_EN is defined.
module div_period_meter #(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    div_period_meter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cap_q, hi_cap_d;
    logic             div_q_q, div_q_d;
    logic [2:0]       ratio_q, ratio_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             match_q, match_d;
    logic             err_timeout_q, err_timeout_d;

    logic             rise, fall, ratio_chg, ratio_ge2;
    logic [CNT_W-1:0] ratio_ext;

    assign rise      = bus.div_in & ~div_q_q;
    assign fall      = ~bus.div_in & div_q_q;
    assign ratio_chg = (bus.ratio != ratio_q);
    assign ratio_ge2 = (ratio_q >= 3'd2);
    assign ratio_ext = {{(CNT_W-3){1'b0}}, ratio_q};

`ifdef DIV_MON_DUTY_CHK_EN
    localparam logic signed [CNT_W+1:0] DIFF_ONE = {{(CNT_W+1){1'b0}}, 1'b1};
    logic                      err_duty_q, err_duty_d;
    logic signed [CNT_W+1:0]   duty_diff;
    logic                      duty_bad;

    // 2*high - period for the period closing on this rise
    assign duty_diff = $signed({1'b0, hi_cap_q, 1'b0}) - $signed({2'b00, cnt_q});
    assign duty_bad  = (duty_diff > DIFF_ONE) || (duty_diff < -DIFF_ONE);
    assign bus.err_duty = err_duty_q;
`else
    assign bus.err_duty = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        hi_cap_d      = hi_cap_q;
        div_q_d       = bus.div_in;
        ratio_d       = bus.ratio;
        valid_d       = 1'b0;
        period_d      = period_q;
        high_time_d   = high_time_q;
        match_d       = match_q;
        err_timeout_d = err_timeout_q;
`ifdef DIV_MON_DUTY_CHK_EN
        err_duty_d    = err_duty_q;
`endif
        if (!bus.meas_en) begin
            state_d       = IDLE;
            cnt_d         = '0;
            hi_cap_d      = '0;
            err_timeout_d = 1'b0;
`ifdef DIV_MON_DUTY_CHK_EN
            err_duty_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d    = '0;
                    hi_cap_d = '0;
                    state_d  = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    // ratio change outranks a coincident rise: partial period is dropped
                    if (ratio_chg) begin
                        cnt_d   = '0;
                        state_d = ARM;
                    end else if (rise) begin
                        period_d    = cnt_q;
                        high_time_d = hi_cap_q;
                        match_d     = (cnt_q == ratio_ext) && ratio_ge2;
                        valid_d     = 1'b1;
                        cnt_d       = CNT_ONE;
`ifdef DIV_MON_DUTY_CHK_EN
                        if (ratio_ge2 && duty_bad) err_duty_d = 1'b1;
`endif
                    end else begin
                        if (fall) hi_cap_d = cnt_q;
                        if (cnt_q == CNT_MAX) begin
                            err_timeout_d = 1'b1;
                            cnt_d         = '0;
                            state_d       = ARM;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            hi_cap_q      <= '0;
            div_q_q       <= 1'b0;
            ratio_q       <= 3'd0;
            valid_q       <= 1'b0;
            period_q      <= '0;
            high_time_q   <= '0;
            match_q       <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            hi_cap_q      <= hi_cap_d;
            div_q_q       <= div_q_d;
            ratio_q       <= ratio_d;
            valid_q       <= valid_d;
            period_q      <= period_d;
            high_time_q   <= high_time_d;
            match_q       <= match_d;
            err_timeout_q <= err_timeout_d;
        end
    end

`ifdef DIV_MON_DUTY_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_duty_q <= 1'b0;
        else      err_duty_q <= err_duty_d;
    end
`endif

    assign bus.valid       = valid_q;
    assign bus.period      = period_q;
    assign bus.high_time   = high_time_q;
    assign bus.match       = match_q;
    assign bus.err_timeout = err_timeout_q;
endmodule

// File: tb/tb_div_period_meter.sv
// tb/tb_div_period_meter.sv - directed self-checking bench for div_period_meter
module tb_div_period_meter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   vcount = 0;

`ifdef DIV_MON_DUTY_CHK_EN
    localparam logic DUTY6 = 1'b1;
`else
    localparam logic DUTY6 = 1'b0;
`endif

    div_period_meter_if #(.CNT_W(8)) bus ();

    div_period_meter #(.CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one div_in sample per clk; outputs observed 1 time unit after the edge
    task automatic step(input logic d);
        bus.div_in = d;
        @(posedge clk);
        #1;
        if (bus.valid) vcount++;
    endtask

    task automatic run_pattern(input string tag, input logic [7:0] pat, input int len,
                               input int reps, input int exp_p, input int exp_h,
                               input logic exp_m, input logic exp_d);
        vcount = 0;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < len; i++) begin
                step(pat[len-1-i]);
                if (bus.valid) begin
                    check({tag, "_period"}, bus.period, exp_p);
                    check({tag, "_high"}, bus.high_time, exp_h);
                    check({tag, "_match"}, bus.match, exp_m);
                    check({tag, "_duty"}, bus.err_duty, exp_d);
                end
            end
        end
        check({tag, "_nvalid"}, vcount, reps - 1);
    endtask

    initial begin
        bus.div_in  = 1'b0;
        bus.ratio   = 3'd0;
        bus.meas_en = 1'b0;
        #1;
        check("rst_valid", bus.valid, 0);
        check("rst_period", bus.period, 0);
        check("rst_high", bus.high_time, 0);
        check("rst_match", bus.match, 0);
        check("rst_tmo", bus.err_timeout, 0);
        check("rst_duty", bus.err_duty, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;

        bus.meas_en = 1'b1;
        bus.ratio   = 3'd4;
        step(1'b0);
        step(1'b0);
        run_pattern("div4", 8'b1100, 4, 4, 4, 2, 1'b1, 1'b0);

        bus.ratio = 3'd5;
        step(1'b0);
        run_pattern("div5", 8'b00011000, 5, 3, 5, 2, 1'b1, 1'b0);

        bus.ratio = 3'd6;
        step(1'b0);
        run_pattern("div6", 8'b00100000, 6, 3, 6, 1, 1'b1, DUTY6);

        bus.meas_en = 1'b0;
        step(1'b0);
        check("off_duty", bus.err_duty, 0);
        check("off_period_hold", bus.period, 6);
        check("off_high_hold", bus.high_time, 1);

        bus.meas_en = 1'b1;
        bus.ratio   = 3'd1;
        step(1'b0);
        step(1'b0);
        run_pattern("r1", 8'b00100000, 6, 3, 6, 1, 1'b0, 1'b0);

        bus.ratio = 3'd2;
        step(1'b0);
        run_pattern("min2", 8'b10, 2, 4, 2, 1, 1'b1, 1'b0);

        // interrupted period: 4 -> 3 mid-period
        bus.ratio = 3'd4;
        step(1'b0);
        run_pattern("pre3", 8'b1100, 4, 2, 4, 2, 1'b1, 1'b0);
        vcount = 0;
        step(1'b1);
        check("pre3_last_valid", vcount, 1);
        step(1'b1);
        bus.ratio = 3'd3;
        vcount = 0;
        step(1'b0);
        step(1'b0);
        check("chg_novalid", vcount, 0);
        run_pattern("div3", 8'b110, 3, 3, 3, 2, 1'b1, 1'b0);

        // rise and ratio change on the same edge: change wins
        bus.ratio = 3'd4;
        vcount = 0;
        step(1'b1);
        check("rise_chg_valid", bus.valid, 0);
        step(1'b0);
        step(1'b0);
        check("rise_chg_nvalid", vcount, 0);
        run_pattern("post", 8'b1100, 4, 2, 4, 2, 1'b1, 1'b0);

        // timeout: one rise then div_in held low
        step(1'b1);
        vcount = 0;
        for (int i = 0; i < 254; i++) step(1'b0);
        check("tmo_before", bus.err_timeout, 0);
        step(1'b0);
        check("tmo_at255", bus.err_timeout, 1);
        for (int i = 0; i < 45; i++) step(1'b0);
        check("tmo_sticky", bus.err_timeout, 1);
        check("tmo_novalid", vcount, 0);
        bus.meas_en = 1'b0;
        step(1'b0);
        check("tmo_clear", bus.err_timeout, 0);
        check("tmo_period_hold", bus.period, 4);

        // asynchronous reset mid-period
        bus.meas_en = 1'b1;
        step(1'b0);
        run_pattern("prerst", 8'b1100, 4, 2, 4, 2, 1'b1, 1'b0);
        step(1'b1);
        step(1'b1);
        check("prerst_period", bus.period, 4);
        rst = 1'b0;
        #1;
        check("arst_period", bus.period, 0);
        check("arst_high", bus.high_time, 0);
        check("arst_match", bus.match, 0);
        check("arst_valid", bus.valid, 0);
        check("arst_tmo", bus.err_timeout, 0);
        check("arst_duty", bus.err_duty, 0);
        step(1'b0);
        rst = 1'b1;
        step(1'b0);
        run_pattern("postrst", 8'b1100, 4, 2, 4, 2, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
